onehot_grant_decoder: RTL

- Decoding end of the 4-input priority-encoder path: takes a 2-bit encoded request plus valid (encoder Out/V) and reconstructs a registered one-hot grant.
- Holds each grant for HOLD_CYCLES cycles, then inserts one idle gap cycle and pulses done.
- A 1-deep pending buffer with valid/ready handshake absorbs a request that arrives while a grant is active.

---
 rtl/onehot_grant_decoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/onehot_grant_decoder.sv
// One-hot grant decoder: turns an encoded request (code + valid) into a registered
// one-hot grant. Each grant is held for HOLD_CYCLES cycles and is followed by a one-cycle done gap.
module onehot_grant_decoder #(
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       pend_code_q, pend_code_d;
    logic             accept;

    function automatic logic [3:0] decode(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    assign in_ready = ~pend_valid_q;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cnt_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_code_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cnt_q         <= cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_code_q   <= pend_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_GRANT;
            S_GRANT: if (cnt_q == '0) state_d = S_GAP;
            S_GAP:   state_d = (pend_valid_q || accept) ? S_GRANT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A pending request always wins in GAP; in_ready is low then, so no new accept can collide.
    always_comb begin
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    grant_d = decode(in_code);
                    cnt_d   = CNT_LOAD;
                end
            end
            S_GRANT: begin
                if (accept) begin
                    pend_valid_d = 1'b1;
                    pend_code_d  = in_code;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    grant_d = '0;
                    done_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (pend_valid_q) begin
                    grant_d      = decode(pend_code_q);
                    pend_valid_d = 1'b0;
                    cnt_d        = CNT_LOAD;
                end else if (accept) begin
                    grant_d = decode(in_code);
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
        grant_valid_d = |grant_d;
        busy_d        = (state_d != S_IDLE);
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
